cnt_seq_checker: RTL and testbench



---
 rtl/cnt_chk_pkg.sv | 17 +
 rtl/cnt_seq_checker_sat_counter.sv | 24 ++
 rtl/cnt_seq_checker.sv | 110 +++++++++++
 tb/tb_cnt_seq_checker.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cnt_chk_pkg.sv
// rtl/cnt_chk_pkg.sv - shared types and default sizes for the counter sequence checker
// Contents:
//   state_t    - checker FSM state (HOLD, RUN, FAIL)
//   DEF_WIDTH  - default width of the counter under check
//   DEF_ERR_W  - default width of the saturating error counter
package cnt_chk_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      FAIL = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/cnt_seq_checker_sat_counter.sv
// rtl/cnt_seq_checker_sat_counter.sv - saturating event counter for the checker error count
// Ports:
//   clk    in         clock, posedge
//   clear  in         synchronous clear, active-high
//   inc    in         count one event this edge
//   count  out ERR_W  current count, holds at all-ones
module cnt_seq_checker_sat_counter #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [ERR_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cnt_seq_checker.sv
// rtl/cnt_seq_checker.sv - observer that rebuilds a free-running up-counter sequence and flags deviations
// Build option: CNT_CHK_RESYNC_EN - when defined, a mismatch resynchronises the
// expected value to the observed count and checking continues; otherwise the
// checker parks in FAIL until the next reset.
// Ports:
//   clk        in          counter clock, all logic on posedge
//   reset      in          counter reset, shared; synchronous, active-high
//   cnt        in  WIDTH   counter value under check
//   mismatch   out         one-cycle pulse: compare failed on the previous edge
//   rst_viol   out         cnt non-zero while reset held for 2+ consecutive edges
//   fail       out         sticky: any mismatch or rst_viol since reset release
//   locked     out         high while in RUN
//   err_count  out ERR_W   saturating count of mismatch events
//   first_exp  out WIDTH   expected value at the first mismatch
//   first_got  out WIDTH   observed value at the first mismatch
module cnt_seq_checker
   import cnt_chk_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ERR_W = DEF_ERR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] cnt,
   output logic             mismatch,
   output logic             rst_viol,
   output logic             fail,
   output logic             locked,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got
);

   state_t           state, state_next;
   logic [WIDTH-1:0] exp, exp_next;
   logic             reset_q;
   logic             mis_next;
   logic             viol_next;

   // The first reset edge is exempt: the counter's own synchronous reset has
   // not landed yet, so only a non-zero count on later reset edges is a fault.
   assign viol_next = reset & reset_q & (cnt != '0);

   always_comb begin
      state_next = state;
      exp_next   = exp;
      mis_next   = 1'b0;
      unique case (state)
         // HOLD compares against exp, which reset left at zero.
         HOLD, RUN: begin
            if (cnt == exp) begin
               state_next = RUN;
               exp_next   = exp + 1'b1;
            end else begin
               mis_next = 1'b1;
`ifdef CNT_CHK_RESYNC_EN
               state_next = RUN;
               exp_next   = cnt + 1'b1;
`else
               state_next = FAIL;
`endif
            end
         end
         FAIL: begin
            state_next = FAIL;
         end
         default: begin
            state_next = HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      reset_q  <= reset;
      rst_viol <= viol_next;
      if (reset) begin
         state     <= HOLD;
         exp       <= '0;
         mismatch  <= 1'b0;
         first_exp <= '0;
         first_got <= '0;
         // The first reset edge clears fail; later held-reset edges keep it
         // sticky so a violation survives until after release.
         fail      <= viol_next | (reset_q & fail);
      end else begin
         state    <= state_next;
         exp      <= exp_next;
         mismatch <= mis_next;
         fail     <= fail | mis_next;
         // err_count only returns to zero through reset, so zero marks the
         // first mismatch since reset.
         if (mis_next && (err_count == '0)) begin
            first_exp <= exp;
            first_got <= cnt;
         end
      end
   end

   assign locked = (state == RUN);

   cnt_seq_checker_sat_counter #(
      .ERR_W (ERR_W)
   ) u_err_count (
      .clk   (clk),
      .clear (reset),
      .inc   (mis_next & ~reset),
      .count (err_count)
   );

endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb/tb_cnt_seq_checker.sv - scoreboard bench for cnt_seq_checker with directed vectors
module tb_cnt_seq_checker;

   localparam int WIDTH = 4;
   localparam int ERR_W = 8;

`ifdef CNT_CHK_RESYNC_EN
   localparam bit RS = 1'b1;
`else
   localparam bit RS = 1'b0;
`endif

   typedef struct packed {
      logic             mis;
      logic             viol;
      logic             fail;
      logic             lock;
      logic [ERR_W-1:0] err;
      logic [WIDTH-1:0] fexp;
      logic [WIDTH-1:0] fgot;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] cnt = '0;
   logic             mismatch;
   logic             rst_viol;
   logic             fail;
   logic             locked;
   logic [ERR_W-1:0] err_count;
   logic [WIDTH-1:0] first_exp;
   logic [WIDTH-1:0] first_got;

   exp_t  sb[$];
   string nq[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   cnt_seq_checker #(
      .WIDTH (WIDTH),
      .ERR_W (ERR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cnt       (cnt),
      .mismatch  (mismatch),
      .rst_viol  (rst_viol),
      .fail      (fail),
      .locked    (locked),
      .err_count (err_count),
      .first_exp (first_exp),
      .first_got (first_got)
   );

   function automatic exp_t ex(input bit mis, input bit viol, input bit fl, input bit lk,
                               input int err, input int fe, input int fg);
      exp_t e;
      e.mis  = mis;
      e.viol = viol;
      e.fail = fl;
      e.lock = lk;
      e.err  = ERR_W'(err);
      e.fexp = WIDTH'(fe);
      e.fgot = WIDTH'(fg);
      return e;
   endfunction

   // Inputs change on the falling edge; the expected outputs after the next
   // rising edge go into the scoreboard.
   task automatic drive(input string nm, input logic r, input logic [WIDTH-1:0] c, input exp_t e);
      @(negedge clk);
      reset = r;
      cnt   = c;
      sb.push_back(e);
      nq.push_back(nm);
   endtask

   // Monitor: sample 1 time unit after every rising edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = sb.pop_front();
         nm = nq.pop_front();
         a  = '{mismatch, rst_viol, fail, locked, err_count, first_exp, first_got};
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got mis=%b viol=%b fail=%b lock=%b err=%0d fexp=%0d fgot=%0d, required mis=%b viol=%b fail=%b lock=%b err=%0d fexp=%0d fgot=%0d",
                     nm, $time, a.mis, a.viol, a.fail, a.lock, a.err, a.fexp, a.fgot,
                     e.mis, e.viol, e.fail, e.lock, e.err, e.fexp, e.fgot);
         end
      end
   end

   initial begin
      exp_t z;
      z = ex(0, 0, 0, 0, 0, 0, 0);

      // Reset one edge, then a clean count through two wraps.
      drive("reset_state", 1, 0, z);
      for (int i = 0; i < 40; i++) drive("count_ok", 0, WIDTH'(i), ex(0, 0, 0, 1, 0, 0, 0));

      // Reset mid-run; non-zero cnt on the first reset edge is exempt.
      drive("rst_exempt", 1, 5, z);
      for (int i = 0; i < 7; i++) drive("count_ok2", 0, WIDTH'(i), ex(0, 0, 0, 1, 0, 0, 0));
      drive("skip_6_8", 0, 8, ex(1, 0, 1, RS, 1, 7, 8));
      drive("after_skip", 0, 9, ex(0, 0, 1, RS, 1, 7, 8));
      drive("second_err", 0, 11, ex(RS, 0, 1, RS, RS ? 2 : 1, 7, 8));

      // Reset after an error clears stats; relock and check a bad wrap.
      drive("rst_clear", 1, 0, z);
      for (int i = 0; i < 16; i++) drive("count_ok3", 0, WIDTH'(i), ex(0, 0, 0, 1, 0, 0, 0));
      drive("bad_wrap", 0, 1, ex(1, 0, 1, RS, 1, 0, 1));

      // Reset held 5 edges with cnt forced to 3 on the third.
      drive("rst_h1", 1, 0, z);
      drive("rst_h2", 1, 0, z);
      drive("rst_force", 1, 3, ex(0, 1, 1, 0, 0, 0, 0));
      drive("rst_h4", 1, 0, ex(0, 0, 1, 0, 0, 0, 0));
      drive("rst_h5", 1, 0, ex(0, 0, 1, 0, 0, 0, 0));
      drive("rel_sticky0", 0, 0, ex(0, 0, 1, 1, 0, 0, 0));
      drive("rel_sticky1", 0, 1, ex(0, 0, 1, 1, 0, 0, 0));

      // Wrong value on the first edge after release.
      drive("rst_pre_hold", 1, 0, z);
      drive("hold_bad", 0, 2, ex(1, 0, 1, RS, 1, 0, 2));
      drive("hold_after", 0, 3, ex(0, 0, 1, RS, 1, 0, 2));

      // 300 consecutive single-step errors: saturation with resync,
      // a single counted error without.
      drive("rst_sat", 1, 0, z);
      drive("relock", 0, 0, ex(0, 0, 0, 1, 0, 0, 0));
      for (int k = 1; k <= 300; k++) begin
         drive("sat", 0, 0, ex(RS ? 1'b1 : (k == 1), 0, 1, RS,
                                RS ? ((k > 255) ? 255 : k) : 1, 1, 0));
      end

      for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending checks, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
